// File: rtl/exibidor_pkg.sv
// exibidor_pkg: segment codes, converter states, slot indices and small helpers
package exibidor_pkg;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {OCIOSO, CONVERTE} estado_t;

    localparam logic [1:0] SLOT_UNI = 2'd0;
    localparam logic [1:0] SLOT_DEZ = 2'd1;
    localparam logic [1:0] SLOT_CEN = 2'd2;

    function automatic logic [3:0] soma3(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

    // Non-decimal nibbles cannot come out of the converter; they show blank.
    function automatic logic [6:0] seg_de(input logic [3:0] n);
        case (n)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/conversor_bcd.sv
// conversor_bcd: sequential double-dabble, 8 steps per conversion, publishes
// the three BCD digits only on the completing edge.
module conversor_bcd
    import exibidor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inicia,
    input  logic [7:0] valor,
    output logic [3:0] centenas,
    output logic [3:0] dezenas,
    output logic [3:0] unidades,
    output logic       ocupado
);
    estado_t     estado_q;
    logic [7:0]  shift_q;
    logic [11:0] bcd_q;
    logic [2:0]  passo_q;
    logic [3:0]  cen_q, dez_q, uni_q;
    logic        ocupado_q;
    logic [11:0] ajuste;
    logic [19:0] prox;

    always_comb begin
        ajuste = {soma3(bcd_q[11:8]), soma3(bcd_q[7:4]), soma3(bcd_q[3:0])};
        prox   = {ajuste, shift_q} << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q  <= OCIOSO;
            shift_q   <= '0;
            bcd_q     <= '0;
            passo_q   <= '0;
            cen_q     <= '0;
            dez_q     <= '0;
            uni_q     <= '0;
            ocupado_q <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: if (inicia) begin
                    shift_q   <= valor;
                    bcd_q     <= '0;
                    passo_q   <= '0;
                    ocupado_q <= 1'b1;
                    estado_q  <= CONVERTE;
                end
                CONVERTE: begin
                    {bcd_q, shift_q} <= prox;
                    passo_q          <= passo_q + 3'd1;
                    if (passo_q == 3'd7) begin
                        cen_q     <= prox[19:16];
                        dez_q     <= prox[15:12];
                        uni_q     <= prox[11:8];
                        ocupado_q <= 1'b0;
                        estado_q  <= OCIOSO;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign centenas = cen_q;
    assign dezenas  = dez_q;
    assign unidades = uni_q;
    assign ocupado  = ocupado_q;
endmodule

// File: rtl/exibidor_decimal.sv
// exibidor_decimal: converts the calculator result to BCD on change and
// time-multiplexes the three digits onto one 7-segment bus with leading-zero blanking.
module exibidor_decimal
    import exibidor_pkg::*;
#(
    parameter int unsigned DIV_MUX = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] valor,
    output logic [6:0] seg,
    output logic [2:0] digito,
    output logic [3:0] centenas,
    output logic [3:0] dezenas,
    output logic [3:0] unidades,
    output logic       ocupado
);
    logic [7:0]  ultimo_q, ultimo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  slot_q, slot_d;
    logic        inicia, vira;

    // ocupado is low exactly when the converter is idle, so it gates new starts.
    always_comb begin
        inicia   = !ocupado && valor != ultimo_q;
        ultimo_d = inicia ? valor : ultimo_q;
        vira     = cnt_q == 16'(DIV_MUX - 1);
        cnt_d    = vira ? 16'd0 : cnt_q + 16'd1;
        slot_d   = !vira ? slot_q : slot_q == SLOT_CEN ? SLOT_UNI : slot_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ultimo_q <= '0;
            cnt_q    <= '0;
            slot_q   <= SLOT_UNI;
        end else begin
            ultimo_q <= ultimo_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
        end
    end

    conversor_bcd u_conv (
        .clk      (clk),
        .rst      (rst),
        .inicia   (inicia),
        .valor    (valor),
        .centenas (centenas),
        .dezenas  (dezenas),
        .unidades (unidades),
        .ocupado  (ocupado)
    );

    always_comb begin
        digito = 3'b001 << slot_q;
        seg    = slot_q == SLOT_UNI ? seg_de(unidades)
               : slot_q == SLOT_DEZ ? ((centenas == 4'd0 && dezenas == 4'd0) ? SEG_BLANK : seg_de(dezenas))
               : slot_q == SLOT_CEN ? (centenas == 4'd0 ? SEG_BLANK : seg_de(centenas))
               : SEG_BLANK;
    end
endmodule

// File: tb/tb_exibidor_decimal.sv
// tb_exibidor_decimal: randomized and directed stimulus checked every cycle
// against a digit-arithmetic model, plus literal expectations from the test plan.
module tb_exibidor_decimal;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] valor = 8'd0;
    logic [6:0] seg;
    logic [2:0] digito;
    logic [3:0] centenas, dezenas, unidades;
    logic       ocupado;

    int checks = 0;
    int errors = 0;

    exibidor_decimal #(.DIV_MUX(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .valor    (valor),
        .seg      (seg),
        .digito   (digito),
        .centenas (centenas),
        .dezenas  (dezenas),
        .unidades (unidades),
        .ocupado  (ocupado)
    );

    always #5 clk = ~clk;

    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int m_ult, m_val, m_left, m_c, m_d, m_u, m_n;

    // Model: a change is accepted only when idle, results appear 8 edges later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ult = 0; m_val = 0; m_left = 0; m_c = 0; m_d = 0; m_u = 0; m_n = 0;
        end else begin
            m_n++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_c = m_val / 100;
                    m_d = (m_val / 10) % 10;
                    m_u = m_val % 10;
                end
            end else if (int'(valor) != m_ult) begin
                m_ult  = int'(valor);
                m_val  = int'(valor);
                m_left = 8;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_seg(input int slot);
        if (slot == 0) return int'(codes[m_u]);
        if (slot == 1) return (m_c == 0 && m_d == 0) ? 0 : int'(codes[m_d]);
        return m_c == 0 ? 0 : int'(codes[m_c]);
    endfunction

    always @(posedge clk) begin
        #1;
        chk("ocupado", int'(ocupado), int'(m_left > 0));
        chk("bcd", int'({centenas, dezenas, unidades}), (m_c << 8) | (m_d << 4) | m_u);
        chk("digito", int'(digito), 1 << ((m_n / DIV) % 3));
        chk("seg", int'(seg), exp_seg((m_n / DIV) % 3));
    end

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic slots_lit(input string nm, input int s_uni, input int s_dez, input int s_cen);
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            chk(nm, int'(seg), digito == 3'b001 ? s_uni : digito == 3'b010 ? s_dez : s_cen);
        end
    endtask

    initial begin
        ciclos(2);
        chk("reset_digito", int'(digito), 1);
        chk("reset_seg", int'(seg), 'h3F);
        chk("reset_ocupado", int'(ocupado), 0);
        rst = 1'b1;
        slots_lit("zero_slots", 'h3F, 0, 0);
        chk("zero_ocupado", int'(ocupado), 0);

        valor = 8'd255;
        ciclos(1);
        chk("busy_start", int'(ocupado), 1);
        ciclos(7);
        chk("busy_last", int'(ocupado), 1);
        ciclos(1);
        chk("busy_end", int'(ocupado), 0);
        chk("c255", int'(centenas), 2);
        chk("d255", int'(dezenas), 5);
        chk("u255", int'(unidades), 5);
        slots_lit("seg255", 'h6D, 'h6D, 'h5B);

        valor = 8'd7;
        ciclos(10);
        chk("bcd7", int'({centenas, dezenas, unidades}), 'h007);
        slots_lit("seg7", 'h07, 0, 0);

        valor = 8'd100;
        ciclos(10);
        slots_lit("seg100", 'h3F, 'h3F, 'h06);

        valor = 8'd12;
        ciclos(1);
        valor = 8'd200;
        ciclos(8);
        chk("first12", int'({centenas, dezenas, unidades}), 'h012);
        ciclos(1);
        chk("restart200", int'(ocupado), 1);
        ciclos(8);
        chk("second200", int'({centenas, dezenas, unidades}), 'h200);

        valor = 8'd99;
        ciclos(5);
        rst = 1'b0;
        #1;
        chk("abort_bcd", int'({centenas, dezenas, unidades}), 0);
        chk("abort_ocupado", int'(ocupado), 0);
        ciclos(2);
        rst = 1'b1;
        ciclos(9);
        chk("redo99", int'({centenas, dezenas, unidades}), 'h099);

        for (int v = 0; v < 256; v++) begin
            valor = 8'(v);
            ciclos(10);
        end

        repeat (300) begin
            valor = 8'($urandom_range(0, 255));
            ciclos($urandom_range(1, 12));
        end
        ciclos(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exibidor_decimal.md
# exibidor_decimal

Display stage downstream of the synchronous calculator: accepts its 8-bit unsigned result, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto one common 7-segment bus. Conversion runs only when the input value changes. Blanked leading zeros keep the display readable. Intended to sit between the calculator output and the board's display pins.

## Interface
- DIV_MUX, default 1000: clock cycles each digit stays selected; legal range 2..65535.
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- valor  in  8  unsigned value to display (calculator result)
- seg  out  7  segments, active-high, seg[0]=a … seg[6]=g
- digito  out  3  one-hot digit enable, active-high; bit0=units, bit1=tens, bit2=hundreds
- centenas, dezenas, unidades  out  4 each  last completed BCD conversion
- ocupado  out  1  high while a conversion is in progress

## Operation
- Register ultimo holds the last converted value.
- Conversion FSM, two states:
  - OCIOSO → CONVERTE on the edge where valor != ultimo. That edge loads valor into the shift register, clears the BCD scratch, copies valor into ultimo, and sets ocupado=1.
  - CONVERTE runs 8 shift-add-3 steps on the next 8 edges (3-bit step counter). Per step, each scratch nibble ≥5 gets +3, then the 20-bit {scratch, shift} shifts left one bit.
  - On the 8th step edge, centenas/dezenas/unidades load the result, ocupado=0, and the FSM returns to OCIOSO.
- valor is ignored while in CONVERTE. If it differs from ultimo on return to OCIOSO, a new conversion starts on the next edge.
- Digit outputs never show partial results; they change only on the completing edge.
- Blanking (seg=0 for the selected slot):
  - Hundreds blank when centenas=0.
  - Tens blank when centenas=0 and dezenas=0.
  - Units are never blanked.
- Segment codes 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex). Nibbles >9 cannot occur; map them to blank.
- Multiplexer:
  - 16-bit counter counts 0..DIV_MUX-1 and wraps.
  - On wrap, the slot index advances units→tens→hundreds→units.
  - digito and seg are combinational from the slot index and the BCD registers, so they change together.

## Timing
- Reset (rst=0): FSM=OCIOSO, ultimo=0, BCD outputs=0, ocupado=0, mux counter=0, slot=units. Consequently digito=001 and seg=3F.
- Latency:
  - valor changes before edge k (FSM idle) → ocupado high from after edge k.
  - New digits are visible after edge k+8; ocupado falls at that edge.
- Back-to-back changes: a value held through a conversion is picked up on edge k+9 at the earliest.
- Reset mid-conversion aborts immediately. Outputs return to reset values and no partial result is published.
- Slot dwell: exactly DIV_MUX cycles; full refresh period is 3·DIV_MUX cycles. Slot rotation is independent of conversion activity.

## Structure
- Shared package exibidor_pkg:
  - segment code constants SEG_0…SEG_9 and SEG_BLANK
  - FSM state enum (OCIOSO, CONVERTE)
  - slot index constants
- Sub-module conversor_bcd holds the FSM, shift register, step counter and BCD output registers.
- The top level holds the change detection, the mux counter/slot and the segment decode.

## Test plan
- Reset, then hold valor=0 → no conversion (ocupado stays 0); digito cycles 001→010→100 with DIV_MUX=4; seg=3F, 00, 00.
- valor=255 → ocupado high for exactly 8 cycles; then centenas=2, dezenas=5, unidades=5; seg per slot is 6D, 6D, 5B.
- valor=7 → 0,0,7; hundreds and tens slots give seg=00, units slot gives 07. valor=100 → tens slot shows 3F (not blanked).
- valor 12→200 on the cycle after a conversion starts → first result 12, then a second conversion completes with 2,0,0; no intermediate digit change.
- rst=0 pulse at step 4 of converting 99 → outputs immediately 0, ocupado=0. After release, the conversion restarts and completes with 0,9,9.
- Sweep valor 0..255 → BCD outputs match the decimal digits for every value.
